// File: rtl/ftab_seg_pkg.sv
// Shared constants and types for the JPEG table-lookup segment server.
package ftab_seg_pkg;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 3;
    localparam int CNT_W      = 2;

    typedef enum logic {
        RUN,
        EOS_WAIT
    } state_t;

    typedef struct packed {
        logic              e;
        logic [DATA_W-1:0] d;
    } tok_t;
endpackage

// File: rtl/seg_out_fifo.sv
// Three-entry shifting FIFO; entry 0 is the registered head seen on the data port.
module seg_out_fifo
    import ftab_seg_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  tok_t             push_tok,
    input  logic             pop,
    output tok_t             head,
    output logic [CNT_W-1:0] count
);
    tok_t             q      [FIFO_DEPTH];
    tok_t             q_next [FIFO_DEPTH];
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] widx;
    logic             do_pop;
    logic             do_push;

    // Vacated slots are zeroed so an empty FIFO presents an all-zero head.
    always_comb begin
        do_pop  = pop && (count != '0);
        widx    = do_pop ? count - CNT_W'(1) : count;
        do_push = push && (widx < CNT_W'(FIFO_DEPTH));
        q_next  = q;
        if (do_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                q_next[i] = q[i+1];
            end
            q_next[FIFO_DEPTH-1] = '0;
        end
        if (do_push) begin
            q_next[widx] = push_tok;
        end
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q[i] <= '0;
            end
            count <= '0;
        end else begin
            q     <= q_next;
            count <= count_next;
        end
    end

    assign head = q[0];
endmodule

// File: rtl/ftab_segment_server.sv
// Table-memory server: address tokens in, 64-bit table words out, EOS passed through in order.
module ftab_segment_server
    import ftab_seg_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] segment_r_addr_d,
    input  logic              segment_r_addr_e,
    input  logic              segment_r_addr_v,
    output logic              segment_r_addr_b,
    output logic [DATA_W-1:0] segment_r_data_d,
    output logic              segment_r_data_e,
    output logic              segment_r_data_v,
    input  logic              segment_r_data_b,
    input  logic              tbl_we,
    input  logic [AW-1:0]     tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic              oob_err
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              inf_v;
    logic              inf_e;
    logic              inf_oob;
    state_t            state;
    state_t            state_next;
    tok_t              head;
    tok_t              push_tok;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occ;
    logic              accept;
    logic              in_range;
    logic              pop;

    // Back-pressure depends only on registered occupancy/state, never on data_b.
    assign occ              = {1'b0, count} + {{CNT_W{1'b0}}, inf_v};
    assign segment_r_addr_b = !reset || (state == EOS_WAIT) || (occ >= (CNT_W+1)'(FIFO_DEPTH));
    assign accept           = segment_r_addr_v && !segment_r_addr_b;
    assign in_range         = segment_r_addr_d < ADDR_W'(DEPTH);
    assign pop              = segment_r_data_v && !segment_r_data_b;

    // The RAM is deliberately outside reset so table contents survive a stream abort.
    always_ff @(posedge clock) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            rd_word <= mem[segment_r_addr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            inf_v   <= 1'b0;
            inf_e   <= 1'b0;
            inf_oob <= 1'b0;
            oob_err <= 1'b0;
            state   <= RUN;
        end else begin
            inf_v   <= accept;
            inf_e   <= accept && segment_r_addr_e;
            inf_oob <= accept && !segment_r_addr_e && !in_range;
            if (accept && !segment_r_addr_e && !in_range) begin
                oob_err <= 1'b1;
            end
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (accept && segment_r_addr_e) state_next = EOS_WAIT;
            EOS_WAIT: if (pop && head.e) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // EOS and out-of-range reads both carry a zero payload.
    always_comb begin
        push_tok.e = inf_e;
        push_tok.d = (inf_e || inf_oob) ? '0 : rd_word;
    end

    seg_out_fifo u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (inf_v),
        .push_tok (push_tok),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign segment_r_data_v = (count != '0);
    assign segment_r_data_d = head.d;
    assign segment_r_data_e = head.e;
endmodule
